// File: rtl/regfile_pkg.sv
// regfile_pkg: definitions shared by the multi-port register file.
// Holds the integer/FP bank split, the clear/ready FSM state type and the
// write-port arbitration helper used by the read-port bypass.
package regfile_pkg;

  // Entries 0..31 hold the integer bank and 32..63 the FP bank.
  localparam int INT_BASE = 0;
  localparam int FP_BASE  = 32;

  // Upper bound on write ports that the arbitration helper can rank.
  localparam int MAX_WR = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Picks the winning write port for one address. hit[j] is set when port j
  // is enabled and targets that address. Returns the highest set index,
  // because the highest-numbered port wins a same-address conflict.
  // Returns -1 when no port hits.
  function automatic int win_port(input logic [MAX_WR-1:0] hit);
    int w;
    w = -1;
    for (int j = 0; j < MAX_WR; j++) begin
      if (hit[j]) w = j;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: issue/writeback bus of the multi-port register file.
// master = decode/issue + writeback side (drives addresses, writes, allocs);
// slave  = the register file (drives ready, read data, busy bits).
interface regfile_mp_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 64,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic                 ready;
  logic [NRD*AW-1:0]    read_addr;
  logic [NRD*XLEN-1:0]  read_data;
  logic [NRD-1:0]       read_busy;
  logic [NWR-1:0]       write_enable;
  logic [NWR*AW-1:0]    write_addr;
  logic [NWR*XLEN-1:0]  write_data;
  logic                 alloc_valid;
  logic [AW-1:0]        alloc_addr;

  modport master (
    input  ready, read_data, read_busy,
    output read_addr, write_enable, write_addr, write_data,
           alloc_valid, alloc_addr
  );

  modport slave (
    output ready, read_data, read_busy,
    input  read_addr, write_enable, write_addr, write_data,
           alloc_valid, alloc_addr
  );

endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port (zero / bypass / stored mux).
// Ports: ready_i gates outputs to 0; addr_i, stored_i (array entry at addr_i),
// busy_i (scoreboard bit at addr_i); the write bus for bypass; data_o, busy_o.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int AW     = 6,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                ready_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [XLEN-1:0]     stored_i,
  input  logic                busy_i,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0]     data_o,
  output logic                busy_o
);

  logic [MAX_WR-1:0] hit;
  int                win;

  always_comb begin
    hit = '0;
    for (int j = 0; j < NWR; j++) begin
      hit[j] = wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr_i);
    end
    win = win_port(hit);

    data_o = '0;
    busy_o = 1'b0;
    if (ready_i && (addr_i != '0)) begin
      if ((BYPASS != 0) && (win >= 0)) begin
        data_o = wr_data_i[win*XLEN +: XLEN];
      end else begin
        data_o = stored_i;
      end
      // A write landing this cycle clears the bit before it is reported,
      // whether or not its data is forwarded.
      busy_o = busy_i && (win < 0);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with bypass and busy
// scoreboard. Ports: clk, rst (async, active high) and bus (slave modport:
// ready, read ports, write ports, alloc). Storage is unreset and is zeroed
// by a post-reset sweep of NREGS cycles before ready rises.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREGS  = 64,
  parameter int NRD    = 2,
  parameter int NWR    = 1,   // at most MAX_WR
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem [NREGS];

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             ready;
  logic             clr_we;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + AW'(1);
      // Last entry is zeroed on this edge, so ready rises with it.
      if (clr_idx_q == AW'(NREGS - 1)) state_d = READY;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready  = (state_q == READY);
    clr_we = (state_q == CLEAR);
  end

  assign bus.ready = ready;

  // ---------------- storage (no reset) ----------------
  // Ascending port order lets the highest-index port's write land last.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx_q] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.write_enable[j] && (bus.write_addr[j*AW +: AW] != '0)) begin
          mem[bus.write_addr[j*AW +: AW]] <= bus.write_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // ---------------- busy scoreboard ----------------
  always_comb begin
    busy_d = busy_q;
    if (ready) begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.write_enable[j]) busy_d[bus.write_addr[j*AW +: AW]] = 1'b0;
      end
      // Applied after the write clear: a new producer outranks a retiring one.
      if (bus.alloc_valid) busy_d[bus.alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // ---------------- read ports ----------------
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rbusy;

    assign ra = bus.read_addr[i*AW +: AW];

    regfile_rdport #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_rdport (
      .ready_i   (ready),
      .addr_i    (ra),
      .stored_i  (mem[ra]),
      .busy_i    (busy_q[ra]),
      .wr_en_i   (bus.write_enable),
      .wr_addr_i (bus.write_addr),
      .wr_data_i (bus.write_data),
      .data_o    (rdat),
      .busy_o    (rbusy)
    );

    assign bus.read_data[i*XLEN +: XLEN] = rdat;
    assign bus.read_busy[i]              = rbusy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: bench for regfile_mp. dut0 = 2 read / 2 write ports with
// bypass, checked against an array model; dut1 = 1/1 without bypass.
// Inputs change 1 ns after the rising edge, outputs are sampled 3 ns after it.
module tb_regfile_mp;

  localparam int NREGS = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(64), .NREGS(64), .NRD(2), .NWR(2)) bus0 ();
  regfile_mp_if #(.XLEN(64), .NREGS(64), .NRD(1), .NWR(1)) bus1 ();

  regfile_mp #(.XLEN(64), .NREGS(64), .NRD(2), .NWR(2), .BYPASS(1)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  regfile_mp #(.XLEN(64), .NREGS(64), .NRD(1), .NWR(1), .BYPASS(0)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  // dut0 stimulus
  logic [1:0]    we;
  logic [AW-1:0] wa [2];
  logic [63:0]   wd [2];
  logic          av;
  logic [AW-1:0] aa;
  logic [AW-1:0] ra [2];
  // dut1 stimulus
  logic          b1_we;
  logic [AW-1:0] b1_wa, b1_ra;
  logic [63:0]   b1_wd;

  assign bus0.write_enable = we;
  assign bus0.write_addr   = {wa[1], wa[0]};
  assign bus0.write_data   = {wd[1], wd[0]};
  assign bus0.alloc_valid  = av;
  assign bus0.alloc_addr   = aa;
  assign bus0.read_addr    = {ra[1], ra[0]};
  assign bus1.write_enable = b1_we;
  assign bus1.write_addr   = b1_wa;
  assign bus1.write_data   = b1_wd;
  assign bus1.alloc_valid  = 1'b0;
  assign bus1.alloc_addr   = '0;
  assign bus1.read_addr    = b1_ra;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of dut0: contents and pending-producer flags.
  logic [63:0] m_mem  [NREGS];
  bit          m_busy [NREGS];
  bit          m_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a read of address a should see right now (entry 0 is hardwired 0,
  // a same-cycle write is forwarded, the later port taking precedence).
  function automatic logic [63:0] exp_data(input logic [AW-1:0] a);
    logic [63:0] r;
    if (!m_ready || a == 0) return 64'h0;
    r = m_mem[a];
    for (int j = 0; j < 2; j++) if (we[j] && wa[j] == a) r = wd[j];
    return r;
  endfunction

  function automatic logic [63:0] exp_busy(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return 64'h0;
    for (int j = 0; j < 2; j++) if (we[j] && wa[j] == a) return 64'h0;
    return {63'h0, m_busy[a]};
  endfunction

  task automatic idle();
    we = 2'b00; av = 1'b0; aa = '0; b1_we = 1'b0;
    for (int j = 0; j < 2; j++) begin wa[j] = '0; wd[j] = '0; end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NREGS; k++) begin m_mem[k] = 64'h0; m_busy[k] = 1'b0; end
  endtask

  // Apply this cycle's inputs to the model, then move to 1 ns after the edge.
  task automatic tick();
    if (m_ready) begin
      for (int j = 0; j < 2; j++) begin
        if (we[j] && wa[j] != 0) m_mem[wa[j]] = wd[j];
        if (we[j]) m_busy[wa[j]] = 1'b0;
      end
      if (av && aa != 0) m_busy[aa] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reads(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_data%0d_a%0d", tag, i, ra[i]), bus0.read_data[i*64 +: 64], exp_data(ra[i]));
      chk($sformatf("%s_busy%0d_a%0d", tag, i, ra[i]), {63'h0, bus0.read_busy[i]}, exp_busy(ra[i]));
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 1) * 32 + $urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    ra[0] = 5; ra[1] = 0; b1_ra = 5;
    model_clear();

    // ---- reset state ----
    #2;
    chk("rst_ready0", {63'h0, bus0.ready}, 64'h0);
    chk("rst_ready1", {63'h0, bus1.ready}, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    chk("rst_rdata", bus0.read_data[63:0], 64'h0);
    chk("rst_rbusy", {63'h0, bus0.read_busy[0]}, 64'h0);

    // ---- first sweep: ready rises on the 64th edge with rst low ----
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 1; e <= NREGS; e++) begin
      @(posedge clk); #2;
      chk($sformatf("sweep_ready_e%0d", e), {63'h0, bus0.ready}, (e == NREGS) ? 64'h1 : 64'h0);
    end
    chk("sweep_ready_dut1", {63'h0, bus1.ready}, 64'h1);
    #1;  // now 1 ns before... realign to edge+1
    @(posedge clk); #1;
    m_ready = 1'b1;

    // ---- every entry reads zero after the sweep ----
    for (int a = 1; a < NREGS; a++) begin
      ra[0] = AW'(a); ra[1] = AW'(NREGS - a);
      #2;
      chk($sformatf("zero_a%0d", a), bus0.read_data[63:0], 64'h0);
      chk($sformatf("zbusy_a%0d", a), {63'h0, bus0.read_busy[0]}, 64'h0);
      tick();
    end

    // ---- write DEAD_BEEF to 5, read in the same cycle ----
    we = 2'b01; wa[0] = 5; wd[0] = 64'hDEAD_BEEF; ra[0] = 5; ra[1] = 6;
    b1_we = 1'b1; b1_wa = 5; b1_wd = 64'hDEAD_BEEF; b1_ra = 5;
    #2;
    chk("byp1_same", bus0.read_data[63:0], 64'hDEAD_BEEF);
    chk("byp0_same", bus1.read_data, 64'h0);
    check_reads("byp1");
    tick(); idle(); #2;
    chk("byp1_next", bus0.read_data[63:0], 64'hDEAD_BEEF);
    chk("byp0_next", bus1.read_data, 64'hDEAD_BEEF);
    tick();

    // ---- write and alloc to entry 0 ----
    we = 2'b11; wa[0] = 0; wa[1] = 0; wd[0] = 64'h1234; wd[1] = 64'h1234;
    av = 1'b1; aa = 0; ra[0] = 0; ra[1] = 0;
    #2;
    check_reads("x0_same");
    tick(); idle(); #2;
    chk("x0_data", bus0.read_data[63:0], 64'h0);
    chk("x0_busy", {63'h0, bus0.read_busy[0]}, 64'h0);
    tick(); #2;
    check_reads("x0_later");
    tick();

    // ---- both ports write 40 ----
    we = 2'b11; wa[0] = 40; wa[1] = 40; wd[0] = 64'hA; wd[1] = 64'hB; ra[0] = 40; ra[1] = 41;
    #2;
    chk("dual40_byp", bus0.read_data[63:0], 64'hB);
    tick(); idle(); #2;
    chk("dual40_next", bus0.read_data[63:0], 64'hB);
    check_reads("dual40");
    tick();

    // ---- scoreboard on entry 7 ----
    av = 1'b1; aa = 7; ra[0] = 7; ra[1] = 7;
    #2;
    chk("alloc7_same", {63'h0, bus0.read_busy[0]}, 64'h0);
    tick(); idle(); #2;
    chk("alloc7_next", {63'h0, bus0.read_busy[0]}, 64'h1);
    we = 2'b01; wa[0] = 7; wd[0] = 64'h77;
    #1;
    chk("wr7_same", {63'h0, bus0.read_busy[0]}, 64'h0);
    tick(); idle(); #2;
    chk("wr7_next", {63'h0, bus0.read_busy[0]}, 64'h0);
    av = 1'b1; aa = 7; we = 2'b10; wa[1] = 7; wd[1] = 64'h78;
    tick(); idle(); #2;
    chk("allocwr7_next", {63'h0, bus0.read_busy[0]}, 64'h1);
    chk("allocwr7_data", bus0.read_data[63:0], 64'h78);
    tick();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 2; j++) begin
        we[j] = ($urandom_range(0, 2) == 0);
        wa[j] = pick_addr();
        wd[j] = {$urandom, $urandom};
        ra[j] = pick_addr();
      end
      av = ($urandom_range(0, 1) == 1);
      aa = pick_addr();
      #2;
      check_reads($sformatf("rnd%0d", n));
      tick();
    end
    idle();

    // ---- reset mid-operation ----
    av = 1'b1; aa = 9;
    tick(); idle(); ra[0] = 9; #2;
    check_reads("pre_rst");
    rst = 1'b1; m_ready = 1'b0;
    #1;
    chk("rst_async_ready", {63'h0, bus0.ready}, 64'h0);
    chk("rst_async_busy", {63'h0, bus0.read_busy[0]}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sweep with writes/allocs driven, interrupted at cycle 20.
    for (int e = 1; e <= 20; e++) begin
      we = 2'b11; wa[0] = AW'($urandom_range(1, 63)); wa[1] = AW'($urandom_range(1, 63));
      wd[0] = {$urandom, $urandom} | 64'h1; wd[1] = {$urandom, $urandom} | 64'h1;
      av = 1'b1; aa = AW'($urandom_range(1, 63));
      @(posedge clk); #1;
    end
    #2;
    chk("mid_sweep_ready", {63'h0, bus0.ready}, 64'h0);
    rst = 1'b1;
    #1;
    chk("mid_sweep_rst_ready", {63'h0, bus0.ready}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 1; e <= NREGS; e++) begin
      we = 2'b11; wa[0] = AW'($urandom_range(1, 63)); wa[1] = AW'($urandom_range(1, 63));
      wd[0] = {$urandom, $urandom} | 64'h1; wd[1] = {$urandom, $urandom} | 64'h1;
      av = 1'b1; aa = AW'($urandom_range(1, 63));
      @(posedge clk); #1;
      if (e == NREGS) idle();
      #1;
      chk($sformatf("resweep_ready_e%0d", e), {63'h0, bus0.ready}, (e == NREGS) ? 64'h1 : 64'h0);
      #1;
      @(posedge clk); #1;
      // Keep the bound tight: the extra edge above is only allowed once ready.
      if (e < NREGS) begin
        chk($sformatf("resweep_hold_e%0d", e), {63'h0, bus0.ready}, (e + 1 == NREGS) ? 64'h1 : 64'h0);
        e++;
        if (e == NREGS) idle();
      end
    end
    model_clear();
    m_ready = 1'b1;
    idle();

    // Nothing written during either sweep survives; no busy bit survives.
    for (int a = 1; a < NREGS; a++) begin
      ra[0] = AW'(a); ra[1] = AW'(a ^ 1);
      #2;
      check_reads($sformatf("post_a%0d", a));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the core: successor to the fixed 2-read/1-write, 64×64 file. Holds the integer bank (x0–x31) and FP bank (f0–f31) in one flat array. Adds configurable port counts, same-cycle write-to-read bypass and a per-register busy scoreboard. After reset, a sweep state machine zeroes the storage so that a plain, unreset RAM array can be used. Sits between decode/issue (reads, allocation) and writeback (writes).

## Interface
- `XLEN`, 64, data width
- `NREGS`, 64, entries (power of 2); entries 0..31 integer, 32..63 FP
- `NRD`, 2, read ports
- `NWR`, 1, write ports
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads
- `AW` is a local constant equal to $clog2(NREGS)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `ready` out 1: 1 = file usable; 0 during reset and the clear sweep
- `read_addr` in NRD*AW: packed read addresses; port i uses slice [i*AW +: AW]
- `read_data` out NRD*XLEN: packed read data
- `read_busy` out NRD: scoreboard bit of each read address
- `write_enable` in NWR: per write port
- `write_addr` in NWR*AW: packed write addresses
- `write_data` in NWR*XLEN: packed write data
- `alloc_valid` in 1: issue marks a destination pending
- `alloc_addr` in AW: destination to mark busy

## Operation
- FSM states:
  - CLEAR is entered asynchronously on `rst` and held while `rst` is high. It stays in CLEAR after reset release while a counter `clr_idx` (reset to 0) writes 0 to entry `clr_idx` each cycle. When `clr_idx` reaches NREGS-1 → READY.
  - READY is normal operation and has no exit except `rst`.
- Reset values: `ready`=0, all busy bits=0, `clr_idx`=0. `read_data` and `read_busy` are forced to 0 while not ready.
- In CLEAR, `write_enable` and `alloc_valid` are ignored.
- Writes (READY only):
  - Port j with `write_enable[j]`=1 and address ≠0 stores `write_data[j]` at the clock edge.
  - Writes to entry 0 are dropped; entry 0 always reads 0 and is never busy.
  - Multiple ports writing the same address in one cycle: the highest-index port wins.
- Reads (combinational), per port:
  - Address 0 → 0.
  - Otherwise, if BYPASS=1 and an enabled write port targets the same address this cycle → that port's data, using the highest-index port on conflict.
  - Otherwise → the stored entry.
- Scoreboard (READY only):
  - A write to address a clears busy[a]. `alloc_valid` sets busy[alloc_addr].
  - Alloc and write to the same address in the same cycle → busy stays 1 (the new producer wins).
  - `alloc_addr`=0 is ignored.
  - `read_busy[i]` = busy[read_addr[i]] after this cycle's write clear. With BYPASS=1, a read whose data is bypassed reports busy=0.
- Widths: addresses are exactly AW bits, so there is no out-of-range case.

## Timing
- Read latency is 0 cycles (combinational from `read_addr`, and from the write ports when BYPASS=1).
- Write latency is 1 edge. With BYPASS=0, the new value is visible the cycle after the write.
- `ready` rises exactly NREGS clock edges after the first rising edge with `rst` low. It is registered.
- `rst` asserted mid-sweep or mid-operation:
  - `ready` drops and busy bits clear immediately (asynchronously).
  - The sweep restarts from 0 after release.
  - Stored data is undefined until the sweep completes.
- Alloc takes effect at the edge: busy is visible the next cycle.

## Structure
- Shared package `regfile_pkg` holds:
  - the bank split constants: INT_BASE=0, FP_BASE=32
  - the FSM state enum {CLEAR, READY}
  - a function that selects the winning write port for a given address
- Sub-module `regfile_rdport`: one read port's bypass/zero/busy mux. It is instantiated NRD times in a generate loop.
- Storage is a plain array with no reset. Only the FSM, the counter and the busy vector have reset.

## Test plan
- Reset release, then idle → `ready`=0 for 64 cycles and 1 on cycle 64. Reads of addresses 1..63 all return 0.
- Write 64'hDEAD_BEEF to addr 5, reading addr 5 in the same cycle:
  - BYPASS=1 → read returns DEAD_BEEF that cycle.
  - BYPASS=0 → read returns 0 that cycle and DEAD_BEEF the next.
- Write 64'h1234 to addr 0 → addr 0 reads 0 on every later cycle, and `read_busy` stays 0.
- NWR=2, both ports write addr 40 (port0 = 64'hA, port1 = 64'hB) → addr 40 reads 64'hB afterwards.
- Scoreboard:
  - Alloc addr 7 → `read_busy` for addr 7 is 1 next cycle.
  - Write to 7 → busy returns to 0.
  - Alloc and write to 7 in the same cycle → busy stays 1.
- Assert `rst` at sweep cycle 20, release, and check:
  - `ready` falls immediately.
  - The sweep restarts from 0, with `ready` rising 64 edges after release.
  - Writes issued during the sweep are not retained.
